// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: control bundle layout, ALU op encodings and
// the small helpers used by the ID/EX stage.
package riscv_pkg;

  localparam int CTRL_W = 9;

  // Bit positions inside {jump, aluop[1:0], alusrc, branch, memtoreg, memwrite, memread, regwrite}
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_ALUOP_LO = 6;
  localparam int CTRL_ALUOP_HI = 7;
  localparam int CTRL_JUMP     = 8;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int          BUBBLE_CNT_W   = 16;
  localparam logic [15:0] BUBBLE_CNT_MAX = 16'hFFFF;

  // EX register occupancy; VALID means the register carries a real instruction.
  typedef enum logic {
    OCC_EMPTY = 1'b0,
    OCC_VALID = 1'b1
  } occ_state_e;

  // What the EX register does on the coming edge, highest priority first.
  typedef enum logic [1:0] {
    ACT_FLUSH  = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_LOAD   = 2'd3
  } ex_action_e;

  function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] v);
    return (v == BUBBLE_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare: the instruction in ID reads a register that
// the load currently in EX has not yet produced.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic       id_valid_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       ex_valid_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  output logic       hazard_o
);

  logic rs1_match;
  logic rs2_match;
  logic ex_is_load;

  assign ex_is_load = ex_valid_i & ex_memread_i & (ex_rd_i != REG_ZERO);
  assign rs1_match  = id_uses_rs1_i & (id_rs1_i == ex_rd_i);
  assign rs2_match  = id_uses_rs2_i & (id_rs2_i == ex_rd_i);
  assign hazard_o   = id_valid_i & ex_is_load & (rs1_match | rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and a
// saturating bubble counter.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              stall_id,
  output logic [15:0]       bubble_cnt
);

  occ_state_e        occ_state_q, occ_state_d;
  ex_action_e        action;
  logic              hazard;

  logic [XLEN-1:0]   ex_pc_q, ex_pc_d;
  logic [XLEN-1:0]   ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]   ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0]   ex_imm_q, ex_imm_d;
  logic [4:0]        ex_rs1_q, ex_rs1_d;
  logic [4:0]        ex_rs2_q, ex_rs2_d;
  logic [4:0]        ex_rd_q, ex_rd_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [15:0]       bubble_cnt_q, bubble_cnt_d;

  load_use_detect u_load_use_detect (
    .id_valid_i    (id_valid),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .ex_valid_i    (ex_valid),
    .ex_memread_i  (ex_ctrl_q[CTRL_MEMREAD]),
    .ex_rd_i       (ex_rd_q),
    .hazard_o      (hazard)
  );

  always_comb begin
    action = ACT_LOAD;
    if (flush) begin
      action = ACT_FLUSH;
    end else if (ex_hold) begin
      action = ACT_HOLD;
    end else if (hazard) begin
      action = ACT_BUBBLE;
    end
  end

  // Flush and bubble both empty the slot; ctrl and rd are cleared so nothing
  // downstream writes and the forwarding compare sees no producer.
  always_comb begin
    occ_state_d   = occ_state_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    ex_ctrl_d     = ex_ctrl_q;
    bubble_cnt_d  = bubble_cnt_q;
    case (action)
      ACT_FLUSH: begin
        occ_state_d = OCC_EMPTY;
        ex_ctrl_d   = '0;
        ex_rd_d     = REG_ZERO;
      end
      ACT_HOLD: begin
      end
      ACT_BUBBLE: begin
        occ_state_d  = OCC_EMPTY;
        ex_ctrl_d    = '0;
        ex_rd_d      = REG_ZERO;
        bubble_cnt_d = sat_inc(bubble_cnt_q);
      end
      default: begin
        occ_state_d   = id_valid ? OCC_VALID : OCC_EMPTY;
        ex_pc_d       = id_pc;
        ex_rs1_data_d = id_rs1_data;
        ex_rs2_data_d = id_rs2_data;
        ex_imm_d      = id_imm;
        ex_rs1_d      = id_rs1;
        ex_rs2_d      = id_rs2;
        ex_rd_d       = id_rd;
        ex_ctrl_d     = id_valid ? id_ctrl : '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_state_q   <= OCC_EMPTY;
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_ctrl_q     <= '0;
      bubble_cnt_q  <= '0;
    end else begin
      occ_state_q   <= occ_state_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_ctrl_q     <= ex_ctrl_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end

  assign ex_valid    = (occ_state_q == OCC_VALID);
  assign ex_pc       = ex_pc_q;
  assign ex_rs1_data = ex_rs1_data_q;
  assign ex_rs2_data = ex_rs2_data_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign ex_rd       = ex_rd_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign bubble_cnt  = bubble_cnt_q;

  // A flush redirects fetch anyway, so it overrides any stall request.
  assign stall_id = !rst & !flush & (ex_hold | hazard);

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a per-cycle vector table followed by
// hand-written hold, saturation and asynchronous-reset sequences.
module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam logic [8:0] C_LW   = 9'h023;
  localparam logic [8:0] C_ADD  = 9'h081;
  localparam logic [8:0] C_ADDI = 9'h0E1;
  localparam logic [8:0] C_ALL  = 9'h1FF;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            id_valid = 1'b0;
  logic [XLEN-1:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [4:0]      id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic            id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic [8:0]      id_ctrl = '0;
  logic            flush = 1'b0, ex_hold = 1'b0;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [8:0]      ex_ctrl;
  logic            stall_id;
  logic [15:0]     bubble_cnt;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_ctrl(id_ctrl),
    .flush(flush), .ex_hold(ex_hold), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .stall_id(stall_id), .bubble_cnt(bubble_cnt)
  );

  // Clock block
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [8:0]  ctrl;
    logic [31:0] pc;
    logic        fl, hold;
    logic        e_stall;
    logic        e_valid;
    logic [8:0]  e_ctrl;
    logic [4:0]  e_rd;
    logic [31:0] e_pc;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic u1, input logic u2,
                              input logic [8:0] ctrl, input logic [31:0] pc,
                              input logic fl, input logic hold, input logic e_stall,
                              input logic e_valid, input logic [8:0] e_ctrl,
                              input logic [4:0] e_rd, input logic [31:0] e_pc,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.u1 = u1; v.u2 = u2;
    v.ctrl = ctrl; v.pc = pc; v.fl = fl; v.hold = hold; v.e_stall = e_stall;
    v.e_valid = e_valid; v.e_ctrl = e_ctrl; v.e_rd = e_rd; v.e_pc = e_pc; v.e_cnt = e_cnt;
    return v;
  endfunction

  function automatic logic [31:0] rs1_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [31:0] rs2_of(input logic [31:0] pc);
    return pc ^ 32'h0000_5A5A;
  endfunction
  function automatic logic [31:0] imm_of(input logic [31:0] pc);
    return pc + 32'd8;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_id(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic u1, input logic u2,
                          input logic [8:0] ctrl, input logic [31:0] pc);
    id_valid = vld; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_ctrl = ctrl; id_pc = pc;
    id_rs1_data = rs1_of(pc); id_rs2_data = rs2_of(pc); id_imm = imm_of(pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ex_valid"},    32'(ex_valid), 32'd0);
    check({tag, ".ex_ctrl"},     32'(ex_ctrl), 32'd0);
    check({tag, ".ex_pc"},       ex_pc, 32'd0);
    check({tag, ".ex_rs1_data"}, ex_rs1_data, 32'd0);
    check({tag, ".ex_rs2_data"}, ex_rs2_data, 32'd0);
    check({tag, ".ex_imm"},      ex_imm, 32'd0);
    check({tag, ".ex_rs1"},      32'(ex_rs1), 32'd0);
    check({tag, ".ex_rs2"},      32'(ex_rs2), 32'd0);
    check({tag, ".ex_rd"},       32'(ex_rd), 32'd0);
    check({tag, ".bubble_cnt"},  32'(bubble_cnt), 32'd0);
    check({tag, ".stall_id"},    32'(stall_id), 32'd0);
  endtask

  logic [15:0] exp_cnt;

  initial begin
    // Vector table: inputs for one cycle, stall_id expected before the edge,
    // register contents expected after it.
    vecs[0]  = mk(1, 2, 3, 5, 1, 0, C_LW,   32'h100, 0, 0,  0, 1, C_LW,   5,  32'h100, 0);
    vecs[1]  = mk(1, 5, 6, 7, 1, 1, C_ADD,  32'h104, 0, 0,  1, 0, 9'h0,   0,  32'h100, 1);
    vecs[2]  = mk(1, 5, 6, 7, 1, 1, C_ADD,  32'h104, 0, 0,  0, 1, C_ADD,  7,  32'h104, 1);
    vecs[3]  = mk(1, 1, 2, 0, 1, 0, C_LW,   32'h108, 0, 0,  0, 1, C_LW,   0,  32'h108, 1);
    vecs[4]  = mk(1, 0, 3, 8, 1, 1, C_ADD,  32'h10C, 0, 0,  0, 1, C_ADD,  8,  32'h10C, 1);
    vecs[5]  = mk(1, 1, 2, 5, 1, 0, C_LW,   32'h110, 0, 0,  0, 1, C_LW,   5,  32'h110, 1);
    vecs[6]  = mk(1, 5, 6, 7, 1, 1, C_ADD,  32'h114, 1, 0,  0, 0, 9'h0,   0,  32'h110, 1);
    vecs[7]  = mk(1, 1, 2, 5, 1, 0, C_LW,   32'h118, 0, 0,  0, 1, C_LW,   5,  32'h118, 1);
    vecs[8]  = mk(1, 1, 5, 9, 1, 0, C_ADDI, 32'h11C, 0, 0,  0, 1, C_ADDI, 9,  32'h11C, 1);
    vecs[9]  = mk(1, 1, 2, 5, 1, 0, C_LW,   32'h120, 0, 0,  0, 1, C_LW,   5,  32'h120, 1);
    vecs[10] = mk(0, 5, 6, 10, 1, 1, C_ADD, 32'h124, 0, 0,  0, 0, 9'h0,   10, 32'h124, 1);
    vecs[11] = mk(1, 1, 2, 5, 1, 0, C_LW,   32'h128, 0, 0,  0, 1, C_LW,   5,  32'h128, 1);
    vecs[12] = mk(1, 1, 5, 11, 1, 1, C_ADD, 32'h12C, 0, 0,  1, 0, 9'h0,   0,  32'h128, 2);
    vecs[13] = mk(1, 1, 5, 11, 1, 1, C_ADD, 32'h12C, 0, 0,  0, 1, C_ADD,  11, 32'h12C, 2);
    vecs[14] = mk(1, 1, 2, 5, 1, 0, C_LW,   32'h130, 0, 1,  1, 1, C_ADD,  11, 32'h12C, 2);
    vecs[15] = mk(1, 1, 2, 5, 1, 0, C_LW,   32'h130, 1, 1,  0, 0, 9'h0,   0,  32'h12C, 2);
    vecs[16] = mk(1, 1, 2, 5, 1, 0, C_LW,   32'h134, 0, 0,  0, 1, C_LW,   5,  32'h134, 2);
    vecs[17] = mk(1, 5, 6, 7, 1, 1, C_ADD,  32'h138, 0, 1,  1, 1, C_LW,   5,  32'h134, 2);
    vecs[18] = mk(1, 5, 6, 7, 1, 1, C_ADD,  32'h138, 0, 0,  1, 0, 9'h0,   0,  32'h134, 3);
    vecs[19] = mk(1, 5, 6, 7, 1, 1, C_ADD,  32'h138, 0, 0,  0, 1, C_ADD,  7,  32'h138, 3);

    // Reset block
    #2 rst = 1'b1;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven cycles
    for (int i = 0; i < 20; i++) begin
      drive_id(vecs[i].vld, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
               vecs[i].u1, vecs[i].u2, vecs[i].ctrl, vecs[i].pc);
      flush = vecs[i].fl;
      ex_hold = vecs[i].hold;
      #1;
      check($sformatf("v%0d.stall_id", i), 32'(stall_id), 32'(vecs[i].e_stall));
      step();
      check($sformatf("v%0d.ex_valid", i), 32'(ex_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d.ex_ctrl", i), 32'(ex_ctrl), 32'(vecs[i].e_ctrl));
      check($sformatf("v%0d.ex_rd", i), 32'(ex_rd), 32'(vecs[i].e_rd));
      check($sformatf("v%0d.ex_pc", i), ex_pc, vecs[i].e_pc);
      check($sformatf("v%0d.bubble_cnt", i), 32'(bubble_cnt), 32'(vecs[i].e_cnt));
      @(negedge clk);
    end
    flush = 1'b0;
    ex_hold = 1'b0;

    // Hold for three cycles, then release
    drive_id(1, 1, 2, 12, 1, 1, C_ADD, 32'h100);
    step();
    check("hold.preload_pc", ex_pc, 32'h100);
    @(negedge clk);
    drive_id(1, 3, 4, 13, 1, 1, C_ADD, 32'h104);
    ex_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("hold%0d.stall_id", c), 32'(stall_id), 32'd1);
      step();
      check($sformatf("hold%0d.ex_pc", c), ex_pc, 32'h100);
      check($sformatf("hold%0d.ex_rd", c), 32'(ex_rd), 32'd12);
      @(negedge clk);
    end
    ex_hold = 1'b0;
    #1 check("release.stall_id", 32'(stall_id), 32'd0);
    step();
    check("release.ex_pc", ex_pc, 32'h104);
    check("release.ex_rs1_data", ex_rs1_data, rs1_of(32'h104));
    check("release.ex_rs2_data", ex_rs2_data, rs2_of(32'h104));
    check("release.ex_imm", ex_imm, imm_of(32'h104));
    check("release.ex_rs1", 32'(ex_rs1), 32'd3);
    check("release.ex_rs2", 32'(ex_rs2), 32'd4);
    check("release.ex_rd", 32'(ex_rd), 32'd13);
    @(negedge clk);

    // Bubble counter: real increments, then pre-set near the top to reach saturation
    exp_cnt = 16'd3;
    for (int n = 0; n < 12; n++) begin
      if (n == 8) begin
        force dut.bubble_cnt_q = 16'hFFFD;
        #1 release dut.bubble_cnt_q;
        exp_cnt = 16'hFFFD;
      end
      drive_id(1, 1, 2, 5, 1, 0, C_LW, 32'h400);
      step();
      @(negedge clk);
      drive_id(1, 5, 6, 7, 1, 1, C_ADD, 32'h404);
      #1 check($sformatf("sat%0d.stall_id", n), 32'(stall_id), 32'd1);
      step();
      exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
      check($sformatf("sat%0d.bubble_cnt", n), 32'(bubble_cnt), 32'(exp_cnt));
      check($sformatf("sat%0d.ex_valid", n), 32'(ex_valid), 32'd0);
      @(negedge clk);
    end

    // Asynchronous reset between edges with a fully set control bundle in EX
    drive_id(1, 1, 2, 5, 1, 0, C_ALL, 32'h200);
    step();
    check("pre_rst.ex_ctrl", 32'(ex_ctrl), 32'(C_ALL));
    check("pre_rst.ex_valid", 32'(ex_valid), 32'd1);
    @(negedge clk);
    drive_id(1, 5, 6, 7, 1, 1, C_ADD, 32'h204);
    ex_hold = 1'b1;
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    ex_hold = 1'b0;
    drive_id(1, 1, 2, 6, 1, 0, C_LW, 32'h300);
    #1 check("post_rst.stall_id", 32'(stall_id), 32'd0);
    step();
    check("post_rst.ex_valid", 32'(ex_valid), 32'd1);
    check("post_rst.ex_ctrl", 32'(ex_ctrl), 32'(C_LW));
    check("post_rst.ex_pc", ex_pc, 32'h300);
    check("post_rst.ex_rd", 32'(ex_rd), 32'd6);
    check("post_rst.bubble_cnt", 32'(bubble_cnt), 32'd0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 id_valid  in  1  ID holds a real instruction.
REQ-005 id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN  ID datapath values.
REQ-006 id_rs1, id_rs2, id_rd  in  5  ID register indices.
REQ-007 id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2.
REQ-008 id_ctrl  in  9  control bundle {jump, aluop[1:0], alusrc, branch, memtoreg, memwrite, memread, regwrite}.
REQ-009 flush  in  1  squash the ID->EX transfer (taken branch/jump redirect).
REQ-010 ex_hold  in  1  EX cannot accept a new instruction; freeze the register.
REQ-011 ex_valid  out  1  EX register holds a real instruction.
REQ-012 ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered datapath values.
REQ-013 ex_rs1, ex_rs2, ex_rd  out  5  registered indices; ex_rs1/ex_rs2 drive the forwarding compare.
REQ-014 ex_ctrl  out  9  registered control bundle.
REQ-015 stall_id  out  1  combinational; when 1, the PC and IF/ID register shall not update.
REQ-016 bubble_cnt  out  16  count of load-use bubbles inserted.

Function
REQ-017 hazard = id_valid & ex_valid & ex_ctrl.memread & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
REQ-018 Per-edge priority, highest first: flush, ex_hold, hazard, load.
REQ-019 flush: ex_valid, ex_ctrl, and ex_rd go to 0; all other ex_* fields hold; flush wins over a simultaneous ex_hold.
REQ-020 ex_hold without flush: every ex_* register and bubble_cnt retains its value.
REQ-021 hazard without flush/ex_hold: bubble inserted; ex_valid, ex_ctrl, and ex_rd go to 0; bubble_cnt increments.
REQ-022 Load: every ex_* field takes the matching id_* value; ex_ctrl takes id_ctrl if id_valid, else 0.
REQ-023 stall_id = !rst & !flush & (ex_hold | hazard).
REQ-024 Latency: ID->EX is one cycle; a load-use dependence costs exactly one bubble, because the bubble clears ex_memread.
REQ-025 Occupancy states: VALID (ex_valid=1) and EMPTY (ex_valid=0).
- Load with id_valid=1 -> VALID.
- Flush, bubble, or load with id_valid=0 -> EMPTY.
- Hold -> unchanged.
REQ-026 Whenever ex_valid=0, ex_ctrl shall be 0, so regwrite/memwrite downstream are inert.
REQ-027 bubble_cnt saturates at 16'hFFFF and shall not wrap.
REQ-028 ex_rd=0, id_valid=0, or a match on an unused source shall produce no bubble.

Reset
REQ-029 rst asserted shall immediately, without a clock edge, clear every ex_* output and bubble_cnt to 0 and force stall_id to 0.
REQ-030 On reset mid-operation, the in-flight EX instruction shall be dropped; the first edge after rst deasserts performs a normal load.

Structure
REQ-031 Shared package riscv_pkg shall hold: CTRL_W=9, ctrl bit-position constants, ALUOP encodings, and REG_ZERO=5'd0.
REQ-032 Sub-module load_use_detect shall contain the combinational hazard compare of REQ-017; registers, priority logic, and the counter stay in id_ex_stage.

Verification
REQ-033 ex_valid=1, ex_ctrl.memread=1, ex_rd=5, ID add with id_uses_rs1=1, id_rs1=5 -> stall_id=1 that cycle; next edge gives ex_valid=0, ex_ctrl=0, bubble_cnt 0->1; following edge loads the add with stall_id=0.
REQ-034 Same as REQ-033 but ex_rd=0, id_rs1=0 -> stall_id=0, add loads next edge, bubble_cnt stays 0.
REQ-035 Hazard of REQ-033 with flush=1 in the same cycle -> stall_id=0, ex_valid=0 after edge, bubble_cnt unchanged.
REQ-036 ex_pc=0x100, ex_hold=1 for 3 cycles, id_pc=0x104 -> ex_pc stays 0x100 and stall_id=1 each cycle; the first edge after release gives ex_pc=0x104.
REQ-037 Drive 65536 consecutive hazard bubbles -> bubble_cnt reaches 0xFFFF and remains 0xFFFF.
REQ-038 Assert rst between clock edges while ex_valid=1 and ex_ctrl=0x1FF -> all outputs 0 immediately; after release, the next edge loads id_* normally.
